// File: rtl/comp_gate_pkg.sv
// Shared types and constants for the multi-channel comparator gate counter.
package comp_gate_pkg;

   localparam int NUM_CH_DEF      = 4;
   localparam int CNT_W_DEF       = 8;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int FILT_LEN_DEF    = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   typedef logic [CNT_W_DEF-1:0] count_t;

   // Comparator-edge to filtered-value delay with the debounce stage built in.
   function automatic int chan_latency(input int sync_stages, input int filt_len);
      return sync_stages + filt_len;
   endfunction

endpackage

// File: rtl/comp_chan_filter.sv
// Synchroniser plus debounce for one comparator channel.
// The debounce stage exists only when COMP_GATE_FILT_EN is defined.
module comp_chan_filter
   import comp_gate_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
`ifdef COMP_GATE_FILT_EN
   ,
   parameter int FILT_LEN    = FILT_LEN_DEF
`endif
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic filt
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;

   // NOTE: flops use <= so every stage samples the value from before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

`ifdef COMP_GATE_FILT_EN
   localparam int RUN_W = $clog2(FILT_LEN + 1);

   logic [RUN_W-1:0] run_q;
   logic             filt_q;

   // run_q counts consecutive synced samples that disagree with the filtered value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q  <= '0;
         filt_q <= 1'b0;
      end else if (synced == filt_q) begin
         run_q <= '0;
      end else if (run_q == RUN_W'(FILT_LEN - 1)) begin
         run_q  <= '0;
         filt_q <= synced;
      end else begin
         run_q <= run_q + 1'b1;
      end
   end

   assign filt = filt_q;
`else
   assign filt = synced;
`endif

endmodule

// File: rtl/comp_gate_counter.sv
// Multi-channel single-slope conversion: gated per-channel counters with valid/ready output.
// Define COMP_GATE_FILT_EN to add the per-channel debounce filter (FILT_LEN exists only then).
module comp_gate_counter
   import comp_gate_pkg::*;
#(
   parameter int NUM_CH      = NUM_CH_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
`ifdef COMP_GATE_FILT_EN
   ,
   parameter int FILT_LEN    = FILT_LEN_DEF
`endif
) (
   input  logic                    Clk,
   input  logic                    Rst_n,
   input  logic                    Start,
   input  logic [NUM_CH-1:0]       Comp_In,
   output logic [NUM_CH-1:0]       Gate_Out,
   output logic                    Busy,
   output logic [NUM_CH*CNT_W-1:0] Count_Out,
   output logic [NUM_CH-1:0]       Ovf,
   output logic                    Valid,
   input  logic                    Ready
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t                        state_q, state_d;
   logic   [NUM_CH-1:0]           filt;
   logic   [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic   [NUM_CH-1:0]           done_q, done_d;
   logic   [NUM_CH-1:0]           ovf_q, ovf_d;
   logic   [NUM_CH-1:0]           gate_q, gate_d;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      comp_chan_filter #(
         .SYNC_STAGES(SYNC_STAGES)
`ifdef COMP_GATE_FILT_EN
         ,
         .FILT_LEN(FILT_LEN)
`endif
      ) u_filter (
         .clk  (Clk),
         .rst_n(Rst_n),
         .raw  (Comp_In[i]),
         .filt (filt[i])
      );
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every signal gets a default first so no latch can be inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      ovf_d   = ovf_q;
      gate_d  = '0;
      unique case (state_q)
         IDLE: begin
            if (Start) begin
               state_d = RUN;
               cnt_d   = '0;
               done_d  = '0;
               ovf_d   = '0;
            end
         end
         RUN: begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (!done_q[i]) begin
                  gate_d[i] = !filt[i];
                  if (filt[i]) begin
                     done_d[i] = 1'b1;
                  end else if (cnt_q[i] != CNT_MAX) begin
                     cnt_d[i] = cnt_q[i] + 1'b1;
                  end else begin
                     done_d[i] = 1'b1;
                     ovf_d[i]  = 1'b1;
                  end
               end
            end
            // Leave on the same edge that retires the last channel.
            if (&done_d) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (Ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt_q  <= '0;
         done_q <= '0;
         ovf_q  <= '0;
         gate_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
         ovf_q  <= ovf_d;
         gate_q <= gate_d;
      end
   end

   assign Count_Out = cnt_q;
   assign Ovf       = ovf_q;
   assign Gate_Out  = gate_q;
   assign Valid     = (state_q == HOLD);
   assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_comp_gate_counter.sv
// Randomised and directed bench for comp_gate_counter against a sample-window reference model.
module tb_comp_gate_counter;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 8;
   localparam int SYNC   = 2;
`ifdef COMP_GATE_FILT_EN
   localparam int FILT   = 3;
   localparam int LAT    = SYNC + FILT;
   localparam int HD     = SYNC + FILT + 1;
`else
   localparam int LAT    = SYNC;
   localparam int HD     = SYNC + 1;
`endif
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic                    Clk     = 1'b0;
   logic                    Rst_n   = 1'b1;
   logic                    Start   = 1'b0;
   logic                    Ready   = 1'b0;
   logic [NUM_CH-1:0]       Comp_In = '0;
   logic [NUM_CH-1:0]       Gate_Out;
   logic                    Busy;
   logic [NUM_CH*CNT_W-1:0] Count_Out;
   logic [NUM_CH-1:0]       Ovf;
   logic                    Valid;

   comp_gate_counter dut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .Start    (Start),
      .Comp_In  (Comp_In),
      .Gate_Out (Gate_Out),
      .Busy     (Busy),
      .Count_Out(Count_Out),
      .Ovf      (Ovf),
      .Valid    (Valid),
      .Ready    (Ready)
   );

   always #5 Clk = ~Clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: raw sample history, window-rule filter, per-channel conversion rules.
   logic [NUM_CH-1:0] m_raw [HD];
   logic [NUM_CH-1:0] m_filt = '0;
   logic [NUM_CH-1:0] m_done = '0;
   logic [NUM_CH-1:0] m_ovf  = '0;
   logic [NUM_CH-1:0] m_gate = '0;
   int                m_cnt [NUM_CH];
   int                m_mode = 0;   // 0 idle, 1 converting, 2 results held

   task automatic model_reset();
      for (int k = 0; k < HD; k++) m_raw[k] = '0;
      for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
      m_filt = '0;
      m_done = '0;
      m_ovf  = '0;
      m_gate = '0;
      m_mode = 0;
   endtask

   task automatic model_step();
      logic [NUM_CH-1:0] f_old;
      if (!Rst_n) begin
         model_reset();
         return;
      end
      f_old = m_filt;
      for (int k = HD - 1; k > 0; k--) m_raw[k] = m_raw[k-1];
      m_raw[0] = Comp_In;
`ifdef COMP_GATE_FILT_EN
      for (int c = 0; c < NUM_CH; c++) begin
         bit all_new = 1'b1;
         for (int j = SYNC; j < SYNC + FILT; j++)
            if (m_raw[j][c] == f_old[c]) all_new = 1'b0;
         if (all_new) m_filt[c] = !f_old[c];
      end
`else
      m_filt = m_raw[SYNC-1];
`endif
      m_gate = '0;
      case (m_mode)
         0: if (Start) begin
            m_mode = 1;
            m_done = '0;
            m_ovf  = '0;
            for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
         end
         1: begin
            for (int c = 0; c < NUM_CH; c++) begin
               if (!m_done[c]) begin
                  m_gate[c] = !f_old[c];
                  if (f_old[c]) m_done[c] = 1'b1;
                  else if (m_cnt[c] < CMAX) m_cnt[c]++;
                  else begin
                     m_done[c] = 1'b1;
                     m_ovf[c]  = 1'b1;
                  end
               end
            end
            if (&m_done) m_mode = 2;
         end
         default: if (Ready) m_mode = 0;
      endcase
   endtask

   always @(negedge Clk) begin
      check("gate", Gate_Out, m_gate);
      check("busy", Busy, (m_mode != 0));
      check("valid", Valid, (m_mode == 2));
      check("ovf", Ovf, m_ovf);
      for (int c = 0; c < NUM_CH; c++)
         check($sformatf("count%0d", c), Count_Out[c*CNT_W +: CNT_W], m_cnt[c]);
   end

   task automatic tick();
      @(posedge Clk);
      model_step();
      #1;
   endtask

   function automatic int cnt_of(input int c);
      return int'(Count_Out[c*CNT_W +: CNT_W]);
   endfunction

   task automatic drain();
      Ready = 1'b1;
      tick();
      Ready = 1'b0;
   endtask

   task automatic run_conv(input int raise_at[NUM_CH], input int pulse_ch, input int pulse_at,
                           input int pulse_len, input int budget, output int hold_n);
      hold_n = -1;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int n = 1; n <= budget; n++) begin
         tick();
         if (Valid) begin
            hold_n = n;
            break;
         end
         for (int c = 0; c < NUM_CH; c++)
            if (raise_at[c] == n) Comp_In[c] = 1'b1;
         if (pulse_ch >= 0 && n == pulse_at) Comp_In[pulse_ch] = 1'b1;
         if (pulse_ch >= 0 && n == pulse_at + pulse_len) Comp_In[pulse_ch] = 1'b0;
      end
      if (hold_n < 0) check("conversion timeout", 0, 1);
   endtask

   initial begin
      int hold_n;
      model_reset();
      #1 Rst_n = 1'b0;
      repeat (3) tick();
      check("reset busy", Busy, 0);
      check("reset valid", Valid, 0);
      check("reset count", Count_Out, 0);
      check("reset gate", Gate_Out, 0);
      Rst_n = 1'b1;
      repeat (LAT + 3) tick();

      // Staggered comparator edges: counts 40/20/10/100.
      run_conv('{40 - LAT, 20 - LAT, 10 - LAT, 100 - LAT}, -1, 0, 0, 150, hold_n);
      check("conv hold cycle", hold_n, 101);
      check("conv ch0", cnt_of(0), 40);
      check("conv ch1", cnt_of(1), 20);
      check("conv ch2", cnt_of(2), 10);
      check("conv ch3", cnt_of(3), 100);
      check("conv ovf", Ovf, 4'b0000);
      check("model ch3", m_cnt[3], 100);

      // Consumer stalls; Start pulses are ignored while results are held.
      for (int k = 0; k < 10; k++) begin
         Start = (k == 3 || k == 6);
         tick();
         Start = 1'b0;
         check("stall valid", Valid, 1);
         check("stall ch0", cnt_of(0), 40);
      end
      drain();
      check("xfer valid", Valid, 0);
      check("xfer busy", Busy, 0);
      check("xfer keep ch3", cnt_of(3), 100);

      // Saturation: only ch1 stays low.
      Comp_In = 4'b1101;
      repeat (LAT + 3) tick();
      run_conv('{-1, -1, -1, -1}, -1, 0, 0, 300, hold_n);
      check("sat hold cycle", hold_n, 256);
      check("sat ch1", cnt_of(1), 255);
      check("sat ch0", cnt_of(0), 0);
      check("sat ovf", Ovf, 4'b0010);
      check("model sat", m_cnt[1], 255);
      drain();

      // Two-cycle glitch on ch2 at cycle 20.
      Comp_In = '0;
      repeat (LAT + 3) tick();
      run_conv('{50 - LAT, 50 - LAT, 50 - LAT, 50 - LAT}, 2, 20, 2, 150, hold_n);
      check("glitch ch0", cnt_of(0), 50);
`ifdef COMP_GATE_FILT_EN
      check("glitch ch2", cnt_of(2), 50);
`else
      check("glitch ch2", cnt_of(2), 20 + SYNC);
`endif
      drain();

      // All comparators high beforehand, Ready already asserted.
      Comp_In = '1;
      Ready   = 1'b1;
      repeat (LAT + 3) tick();
      Start = 1'b1;
      tick();
      Start = 1'b0;
      check("allhi valid early", Valid, 0);
      tick();
      check("allhi valid", Valid, 1);
      check("allhi count", Count_Out, 0);
      tick();
      check("allhi xfer", Valid, 0);
      Ready = 1'b0;

      // Asynchronous reset in the middle of a conversion.
      Comp_In = '0;
      repeat (LAT + 3) tick();
      Start = 1'b1;
      tick();
      Start = 1'b0;
      repeat (10) tick();
      check("pre-reset ch0", cnt_of(0), 10);
      check("pre-reset gate", Gate_Out, 4'hF);
      #2 Rst_n = 1'b0;
      model_reset();
      #1;
      check("mid-rst busy", Busy, 0);
      check("mid-rst gate", Gate_Out, 0);
      check("mid-rst count", Count_Out, 0);
      check("mid-rst valid", Valid, 0);
      tick();
      Rst_n = 1'b1;
      tick();
      check("post-rst idle", Busy, 0);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      check("post-rst start", Busy, 1);
      Comp_In = '1;
      hold_n = -1;
      for (int n = 0; n < 30 && hold_n < 0; n++) begin
         tick();
         if (Valid) hold_n = n;
      end
      if (hold_n < 0) check("post-rst timeout", 0, 1);
      drain();

      // Random traffic with one asynchronous reset.
      for (int n = 0; n < 3000; n++) begin
         Start = ($urandom_range(0, 5) == 0);
         Ready = ($urandom_range(0, 3) != 0);
         for (int c = 0; c < NUM_CH; c++)
            if ($urandom_range(0, 29) == 0) Comp_In[c] = ~Comp_In[c];
         if (n == 1700) begin
            #2 Rst_n = 1'b0;
            model_reset();
         end
         tick();
         if (n == 1700) Rst_n = 1'b1;
      end
      Start = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
